acqbuf_capture: RTL
===================

Name: acqbuf_capture

Overview:
- Trigger-armed acquisition writer in the DSP clock domain, directly downstream of the ADC stream clock-domain crossing.
- Consumes one ADC sample word per clock, already in the DSP domain.
- After arm and trigger, waits a programmable delay, then writes a decimated block of words into the acquisition BRAM through a write port (addr/data/we).
- Reports busy/done status to the register file for host readout.

Parameters:
- DW, 128, ADC sample-word width (bits per clock, all lanes packed).
- AW, 9, BRAM word-address width; max capture depth 2^AW words.
- DECW, 8, decimation-control width.
- DLYW, 16, trigger-delay counter width.

Ports:
- clk  input  1  DSP clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  arm request, single-cycle pulse.
- abort  input  1  cancel capture, single-cycle pulse.
- trigger  input  1  capture trigger, level-sampled while armed.
- delay  input  DLYW  trigger-to-capture delay in clk cycles.
- decim  input  DECW  write one word every decim+1 cycles.
- nwords  input  AW+1  words to capture, 0..2^AW.
- adc  input  DW  ADC sample word, valid every cycle.
- bram_addr  output  AW  BRAM write address (word units).
- bram_data  output  DW  BRAM write data.
- bram_we  output  1  BRAM write enable.
- busy  output  1  high in ARMED/DELAY/CAPTURE.
- done  output  1  high in DONE until next start or abort.
- wcount  output  AW+1  words written in the current/last capture.

Behaviour:
- Reset: state=IDLE; bram_we=0, bram_addr=0, bram_data=0, busy=0, done=0, wcount=0; all counters 0. Reset overrides every other input in every state.
- All outputs are registered.
- States: IDLE, ARMED, DELAY, CAPTURE, DONE.
- IDLE or DONE, start=1:
  - latch delay, decim, nwords; clear wcount, bram_addr, done.
  - if latched nwords==0: go to DONE next cycle, no writes.
  - else: go to ARMED with busy=1.
- start in ARMED/DELAY/CAPTURE: ignored; latched values are unchanged.
- ARMED: trigger sampled from the cycle after entry (trigger coincident with start is ignored).
  - trigger=1 and delay==0: go to CAPTURE.
  - trigger=1 and delay!=0: go to DELAY with counter=delay-1.
- DELAY: decrement each cycle; when counter==0, go to CAPTURE next cycle. Total trigger-to-CAPTURE-entry time is delay+1 cycles. trigger is ignored.
- CAPTURE:
  - decimation counter starts at 0 on entry.
  - on any cycle with counter==0: register adc into bram_data, assert bram_we for that single cycle, and set bram_addr = wcount[AW-1:0].
  - the counter then reloads to the latched decim and decrements each following cycle.
  - write latency: adc sampled at cycle n appears on bram_data/bram_we at n+1.
  - wcount increments with each write. When the write making wcount==nwords issues, go to DONE.
  - trigger is ignored.
- DONE: busy=0, done=1, bram_we=0; bram_addr holds its last value.
- Wrap/boundary:
  - nwords=2^AW writes addresses 0..2^AW-1 exactly once; no address wrap inside one capture.
  - nwords > 2^AW is clamped to 2^AW at latch.
  - decim=0 writes every cycle; decim=2^DECW-1 writes every 2^DECW cycles.
- abort in any non-IDLE state: go to IDLE next cycle.
  - bram_we deasserted that same next cycle; any write on the abort cycle itself still completes.
  - busy=0, done=0; wcount holds the partial count.
  - abort and start in the same cycle: abort wins.
- reset mid-capture: next cycle matches the reset state exactly; no further writes.

Test Plan:
- Basic capture:
  - stimulus: decim=0, delay=0, nwords=4, adc = cycle counter; start, trigger 5 cycles later.
  - required: 4 consecutive bram_we at addr 0..3; data = adc value from the previous cycle; done=1 the cycle after the last write; wcount=4.
- Decimation and delay:
  - stimulus: decim=2, delay=10, nwords=3.
  - required: first write exactly 12 cycles after the trigger cycle (11 to enter CAPTURE, +1 write latency); writes spaced 3 cycles apart at addr 0,1,2.
- Zero and full depth:
  - stimulus: nwords=0, then nwords=512 (AW=9).
  - required: nwords=0 gives done next cycle with no bram_we. nwords=512 gives 512 writes at addr 0..511 with no repeat; nwords=600 also gives 512 writes.
- Ignored inputs:
  - stimulus: start coincident with trigger; then trigger at cycle+2; then start and trigger pulsed again during CAPTURE.
  - required: capture begins from the second trigger; the later start/trigger pulses have no effect.
- Abort and reset mid-capture:
  - stimulus: abort after 3 of 8 writes; then a fresh capture with reset asserted mid-CAPTURE.
  - required: after abort, no bram_we from the next cycle, busy=0, done=0, wcount=3. After reset, all outputs return to their reset values the next cycle.
- Re-arm from DONE:
  - stimulus: start issued while in DONE.
  - required: done clears the next cycle, addr restarts at 0, and the new latched parameters are used.

Source files
------------

// File: rtl/acqbuf_capture_if.sv
// Control/status and BRAM write-port bundle for the acquisition capture writer.
// The slave side is the capture engine; the master side is whatever drives the
// arm/trigger controls and observes the BRAM write port and status.
interface acqbuf_capture_if #(
  parameter int DW   = 128,
  parameter int AW   = 9,
  parameter int DECW = 8,
  parameter int DLYW = 16
);
  logic            start;
  logic            abort;
  logic            trigger;
  logic [DLYW-1:0] delay;
  logic [DECW-1:0] decim;
  logic [AW:0]     nwords;
  logic [DW-1:0]   adc;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_data;
  logic            bram_we;
  logic            busy;
  logic            done;
  logic [AW:0]     wcount;

  modport master (
    output start, abort, trigger, delay, decim, nwords, adc,
    input  bram_addr, bram_data, bram_we, busy, done, wcount
  );

  modport slave (
    input  start, abort, trigger, delay, decim, nwords, adc,
    output bram_addr, bram_data, bram_we, busy, done, wcount
  );
endinterface

// File: rtl/acqbuf_capture.sv
// Trigger-armed acquisition writer: arm, wait for trigger, wait a programmable
// delay, then write a decimated block of ADC words into the acquisition BRAM.
// All outputs are registered; the write port lags the sampled ADC word by one clk.
module acqbuf_capture #(
  parameter int DW   = 128,
  parameter int AW   = 9,
  parameter int DECW = 8,
  parameter int DLYW = 16
) (
  input  logic            clk,
  input  logic            reset,
  acqbuf_capture_if.slave acq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  // Requests deeper than the BRAM saturate to the full depth.
  function automatic logic [AW:0] sat_nwords(input logic [AW:0] n);
    return (n > DEPTH) ? DEPTH : n;
  endfunction

  state_t          state, state_nx;
  logic [DLYW-1:0] dly_l, dly_l_nx, dly_cnt, dly_cnt_nx;
  logic [DECW-1:0] dec_l, dec_l_nx, dec_cnt, dec_cnt_nx;
  logic [AW:0]     nw_l, nw_l_nx, wcount_r, wcount_nx;
  logic [AW-1:0]   addr_r, addr_nx;
  logic [DW-1:0]   data_r, data_nx;
  logic            we_r, we_nx, busy_r, busy_nx, done_r, done_nx;
  logic [AW:0]     nw_sat;

  assign nw_sat        = sat_nwords(acq.nwords);
  assign acq.bram_addr = addr_r;
  assign acq.bram_data = data_r;
  assign acq.bram_we   = we_r;
  assign acq.busy      = busy_r;
  assign acq.done      = done_r;
  assign acq.wcount    = wcount_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; abort outranks every other request, including start.
  always_comb begin
    state_nx = state;
    if (acq.abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (acq.start) state_nx = (nw_sat == '0) ? S_DONE : S_ARMED;
        S_ARMED:        if (acq.trigger) state_nx = (dly_l == '0) ? S_CAPTURE : S_DELAY;
        S_DELAY:        if (dly_cnt == '0) state_nx = S_CAPTURE;
        S_CAPTURE:      if (wcount_r == nw_l) state_nx = S_DONE;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  // Next values of the latched parameters, counters and registered outputs.
  always_comb begin
    dly_l_nx   = dly_l;
    dec_l_nx   = dec_l;
    nw_l_nx    = nw_l;
    dly_cnt_nx = dly_cnt;
    dec_cnt_nx = (state == S_CAPTURE) ? dec_cnt : '0;
    wcount_nx  = wcount_r;
    addr_nx    = addr_r;
    data_nx    = data_r;
    we_nx      = 1'b0;
    if (!acq.abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (acq.start) begin
            dly_l_nx  = acq.delay;
            dec_l_nx  = acq.decim;
            nw_l_nx   = nw_sat;
            wcount_nx = '0;
            addr_nx   = '0;
          end
        end
        S_ARMED: begin
          if (acq.trigger && dly_l != '0) dly_cnt_nx = dly_l - DLYW'(1);
        end
        S_DELAY: begin
          if (dly_cnt != '0) dly_cnt_nx = dly_cnt - DLYW'(1);
        end
        S_CAPTURE: begin
          // The final write has already issued once wcount reaches nw_l.
          if (wcount_r != nw_l) begin
            if (dec_cnt == '0) begin
              addr_nx    = wcount_r[AW-1:0];
              data_nx    = acq.adc;
              we_nx      = 1'b1;
              wcount_nx  = wcount_r + (AW+1)'(1);
              dec_cnt_nx = dec_l;
            end else begin
              dec_cnt_nx = dec_cnt - DECW'(1);
            end
          end
        end
        default: ;
      endcase
    end
    busy_nx = (state_nx == S_ARMED) || (state_nx == S_DELAY) || (state_nx == S_CAPTURE);
    done_nx = (state_nx == S_DONE);
  end

  // Register parameters, counters and outputs; reset returns every one to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_l    <= '0;
      dec_l    <= '0;
      nw_l     <= '0;
      dly_cnt  <= '0;
      dec_cnt  <= '0;
      wcount_r <= '0;
      addr_r   <= '0;
      data_r   <= '0;
      we_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      dly_l    <= dly_l_nx;
      dec_l    <= dec_l_nx;
      nw_l     <= nw_l_nx;
      dly_cnt  <= dly_cnt_nx;
      dec_cnt  <= dec_cnt_nx;
      wcount_r <= wcount_nx;
      addr_r   <= addr_nx;
      data_r   <= data_nx;
      we_r     <= we_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
    end
  end

endmodule
